// File: rtl/bcrypt_cmp_config_dispatch_pkg.sv
// Shared constants and types for the CMP_CONFIG apply sequencer.
package bcrypt_cmp_config_dispatch_pkg;

  // Config store layout: iter_count first, then the salt words.
  localparam int CFG_ADDR_ITER  = 0;
  localparam int CFG_ADDR_SALT0 = 1;
  localparam int CFG_NUM_SALT   = 4;
  localparam int CFG_NUM_WORDS  = CFG_ADDR_SALT0 + CFG_NUM_SALT;

  // Core-array init bus widths.
  localparam int CFG_ADDR_W = 4;
  localparam int CFG_DATA_W = 32;
  localparam int CFG_GEN_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_BCAST   = 3'd2,
    ST_APPLY   = 3'd3,
    ST_RELEASE = 3'd4
  } disp_state_e;

endpackage

// File: rtl/bcrypt_cmp_config_dispatch_drain_detect.sv
// Drain detection: idle-streak counter plus drain watchdog.
// Both counters are held at zero whenever run_i is low, so every drain
// episode starts from a clean count. The timeout flag is sticky until reset.
module bcrypt_cmp_config_dispatch_drain_detect #(
  parameter int TIMEOUT_W = 16
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic run_i,
  input  logic all_idle_i,
  output logic drained_o,
  output logic timeout_o
);

  localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;

  logic [1:0]           streak_q, streak_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 timeout_q, timeout_d;

  // Next-state for streak (saturating at 2), watchdog (saturating) and flag.
  always_comb begin
    streak_d  = 2'd0;
    wdog_d    = '0;
    timeout_d = timeout_q;
    if (run_i) begin
      if (all_idle_i) begin
        streak_d = (streak_q == 2'd2) ? 2'd2 : streak_q + 2'd1;
      end
      wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + TIMEOUT_W'(1);
      if (wdog_d == WDOG_MAX) begin
        timeout_d = 1'b1;
      end
    end
  end

  // Counter and flag registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      streak_q  <= 2'd0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      streak_q  <= streak_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  // Second consecutive idle cycle: a job launched just before hold took
  // effect would have shown up as busy in one of the two.
  assign drained_o = run_i && all_idle_i && (streak_q == 2'd1);
  assign timeout_o = timeout_q;

endmodule

// File: rtl/bcrypt_cmp_config_dispatch.sv
// CMP_CONFIG apply sequencer: holds job issue, drains the cores, broadcasts
// the stored config words to every core, then pulses the applied handshake.
//
// state   | meaning
// IDLE    | no apply in progress, jobs flow freely
// DRAIN   | job issue held, waiting for two consecutive all-idle cycles
// BCAST   | reading config words 0..NUM_WORDS-1, one per cycle
// APPLY   | last word being written; applied pulse and gen bump follow
// RELEASE | hold kept until the parser drops its request
module bcrypt_cmp_config_dispatch
  import bcrypt_cmp_config_dispatch_pkg::*;
#(
  parameter int NUM_CORES = 12,
  parameter int NUM_WORDS = CFG_NUM_WORDS,
  parameter int TIMEOUT_W = 16
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  new_cmp_config,
  output logic                  cmp_config_applied,
  input  logic                  sign_extension_bug,
  input  logic [NUM_CORES-1:0]  cores_idle,
  output logic                  job_hold,
  output logic [CFG_ADDR_W-1:0] cfg_rd_addr,
  input  logic [CFG_DATA_W-1:0] cfg_rd_data,
  output logic                  core_cfg_wr_en,
  output logic [CFG_ADDR_W-1:0] core_cfg_addr,
  output logic [CFG_DATA_W-1:0] core_cfg_data,
  output logic                  core_cfg_sxbug,
  output logic [CFG_GEN_W-1:0]  config_gen,
  output logic                  drain_timeout
);

  localparam logic [CFG_ADDR_W-1:0] LAST_ADDR  = CFG_ADDR_W'(NUM_WORDS - 1);
  localparam logic [CFG_ADDR_W-1:0] FIRST_ADDR = CFG_ADDR_W'(CFG_ADDR_ITER);

  disp_state_e           state_q, state_d;
  logic [CFG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic                  job_hold_q;
  logic                  applied_q;
  logic                  wr_en_q;
  logic [CFG_ADDR_W-1:0] wr_addr_q;
  logic [CFG_DATA_W-1:0] wr_data_q;
  logic                  sxbug_q;
  logic [CFG_GEN_W-1:0]  gen_q;
  logic                  drained;
  logic                  timeout;

  bcrypt_cmp_config_dispatch_drain_detect #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_drain (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .run_i      (state_q == ST_DRAIN),
    .all_idle_i (&cores_idle),
    .drained_o  (drained),
    .timeout_o  (timeout)
  );

  // Next-state and store read address.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      ST_IDLE: begin
        rd_addr_d = '0;
        if (new_cmp_config) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          state_d   = ST_BCAST;
          rd_addr_d = FIRST_ADDR;
        end
      end
      ST_BCAST: begin
        if (rd_addr_q == LAST_ADDR) begin
          state_d   = ST_APPLY;
          rd_addr_d = '0;
        end else begin
          rd_addr_d = rd_addr_q + CFG_ADDR_W'(1);
        end
      end
      ST_APPLY: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!new_cmp_config) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rd_addr_d = '0;
      end
    endcase
  end

  // State and read-address registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Registered outputs: broadcast bus lags the read address by one cycle,
  // so the applied pulse lands the cycle after the final write strobe.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      job_hold_q <= 1'b0;
      applied_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      sxbug_q    <= 1'b0;
      gen_q      <= '0;
    end else begin
      job_hold_q <= (state_d != ST_IDLE);
      applied_q  <= (state_q == ST_APPLY);
      wr_en_q    <= (state_q == ST_BCAST);
      if (state_q == ST_BCAST) begin
        wr_addr_q <= rd_addr_q;
        wr_data_q <= cfg_rd_data;
        if (rd_addr_q == FIRST_ADDR) begin
          sxbug_q <= sign_extension_bug;
        end
      end
      if (state_q == ST_APPLY) begin
        gen_q <= gen_q + CFG_GEN_W'(1);
      end
    end
  end

  assign cmp_config_applied = applied_q;
  assign job_hold           = job_hold_q;
  assign cfg_rd_addr        = rd_addr_q;
  assign core_cfg_wr_en     = wr_en_q;
  assign core_cfg_addr      = wr_addr_q;
  assign core_cfg_data      = wr_data_q;
  assign core_cfg_sxbug     = sxbug_q;
  assign config_gen         = gen_q;
  assign drain_timeout      = timeout;

endmodule
